cacheline_burst_adaptor: RTL

- Sits directly downstream of the cache, between the cache's pmem_* port and the physical memory.
- Converts one full-line read or write request (default 256 bits) into a burst of fixed-width beats (default 4 x 64 bits) on the memory bus.
- Presents the single-cycle line response the cache control expects.
- Handles one transaction at a time.

---
 rtl/cacheline_burst_adaptor_if.sv | 22 ++
 rtl/cacheline_burst_adaptor.sv | 61 ++++++
 2 files changed

// File: rtl/cacheline_burst_adaptor_if.sv
// cacheline_burst_adaptor_if: cache-side line port and memory-side burst port.
interface cacheline_if #(parameter int width = 256);
    logic             read;
    logic             write;
    logic [31:0]      address;
    logic [width-1:0] wdata;
    logic [width-1:0] rdata;
    logic             resp;
    modport master(output read, write, address, wdata, input rdata, resp);
    modport slave(input read, write, address, wdata, output rdata, resp);
endinterface

interface burst_if #(parameter int burst_width = 64);
    logic                   read;
    logic                   write;
    logic [31:0]            address;
    logic [burst_width-1:0] wdata;
    logic [burst_width-1:0] rdata;
    logic                   resp;
    modport master(output read, write, address, wdata, input rdata, resp);
    modport slave(input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: splits one cache line request into a burst of memory beats.
module cacheline_burst_adaptor #(
    parameter int width       = 256,
    parameter int burst_width = 64,
    parameter int s_offset    = 5
) (
    input  logic       clk,
    input  logic       rst,
    cacheline_if.slave line,
    burst_if.master    burst
);
    localparam int beats    = width / burst_width;
    localparam int cnt_bits = $clog2(beats);
    localparam int cw       = cnt_bits > 0 ? cnt_bits : 1;
    localparam logic [cw-1:0] last = cw'(beats - 1);
    typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST, DONE} state_t;
    state_t           state, state_next;
    logic [cw-1:0]    cnt;
    logic [width-1:0] wbuf, rbuf;
    logic [31:0]      addr, line_base;
    logic             in_burst, beat_last;
    assign line_base = line.address & ~((32'd1 << s_offset) - 32'd1);
    assign in_burst  = state == READ_BURST || state == WRITE_BURST;
    assign beat_last = burst.resp && cnt == last;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:                    state_next = line.write ? WRITE_BURST : line.read ? READ_BURST : IDLE;
            READ_BURST, WRITE_BURST: state_next = beat_last ? DONE : state;
            default:                 state_next = IDLE;
        endcase
    end
    // Read beats land in the fill buffer lowest-order first; it is only touched by read beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            addr <= '0;
            wbuf <= '0;
            rbuf <= '0;
        end else if (state == IDLE) begin
            if (line.read || line.write) begin
                addr <= line_base;
                cnt  <= '0;
            end
            if (line.write) wbuf <= line.wdata;
        end else if (in_burst && burst.resp) begin
            cnt <= beat_last ? '0 : cnt + cw'(1);
            if (state == READ_BURST) rbuf[cnt*burst_width +: burst_width] <= burst.rdata;
        end
    end
    assign line.rdata    = rbuf;
    assign line.resp     = state == DONE;
    assign burst.read    = state == READ_BURST;
    assign burst.write   = state == WRITE_BURST;
    assign burst.address = addr;
    assign burst.wdata   = state == WRITE_BURST ? wbuf[cnt*burst_width +: burst_width] : '0;
endmodule
